// File: rtl/dac_cmd_sequencer.sv
// rtl/dac_cmd_sequencer.sv - DAC write-request FIFO with frame-paced issue to the SPI serialiser (optional refresh: DAC_REFRESH_EN)
module dac_cmd_sequencer #(
  parameter int DEPTH          = 8,
  parameter int FRAME_CYCLES   = 26,
  parameter int GAP_CYCLES     = 2,
  parameter int REFRESH_PERIOD = 25000
) (
  input  logic                     clk25,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [3:0]               wr_cmd,
  input  logic [3:0]               wr_addr,
  input  logic [15:0]              wr_value,
  output logic                     wr_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic [3:0]               cmd,
  output logic [3:0]               addr,
  output logic [15:0]              value,
  output logic                     send_data,
  output logic                     refresh_active
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int PACE = FRAME_CYCLES + GAP_CYCLES;
  localparam int PW   = $clog2(PACE + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state, state_n;
  logic [PW-1:0]  pace, pace_n;
  logic [23:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count_n;
  logic [23:0]    head;
  logic           push, issue_fifo, issue_refresh;
  logic           refresh_go;
  logic [23:0]    refresh_word;

  assign push = wr_en && wr_ready;
  assign head = mem[rd_ptr];
  assign busy = (state == WAIT) || (fifo_count != '0);

  // Next state: FIFO issue has priority over refresh; WAIT counts the frame plus gap down
  always_comb begin
    state_n       = state;
    pace_n        = pace;
    issue_fifo    = 1'b0;
    issue_refresh = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          issue_fifo = 1'b1;
          state_n    = WAIT;
          pace_n     = PW'(PACE - 1);
        end else if (refresh_go) begin
          issue_refresh = 1'b1;
          state_n       = WAIT;
          pace_n        = PW'(PACE - 1);
        end
      end
      WAIT: begin
        pace_n = pace - PW'(1);
        if (pace == PW'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FIFO occupancy after this cycle's push/pop; full is judged on the value at cycle start
  always_comb begin
    count_n = fifo_count;
    case ({push, issue_fifo})
      2'b10:   count_n = fifo_count + CW'(1);
      2'b01:   count_n = fifo_count - CW'(1);
      default: count_n = fifo_count;
    endcase
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk25) begin
    if (push) mem[wr_ptr] <= {wr_cmd, wr_addr, wr_value};
  end

  // Control registers, FIFO pointers and the held serialiser word
  always_ff @(posedge clk25) begin
    if (reset) begin
      state      <= IDLE;
      pace       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      wr_ready   <= 1'b1;
      overflow   <= 1'b0;
      send_data  <= 1'b0;
      cmd        <= '0;
      addr       <= '0;
      value      <= '0;
    end else begin
      state      <= state_n;
      pace       <= pace_n;
      fifo_count <= count_n;
      wr_ready   <= (count_n != CW'(DEPTH));
      overflow   <= wr_en && !wr_ready;
      send_data  <= issue_fifo || issue_refresh;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (issue_fifo) begin
        rd_ptr <= rd_ptr + AW'(1);
        {cmd, addr, value} <= head;
      end else if (issue_refresh) begin
        {cmd, addr, value} <= refresh_word;
      end
    end
  end

`ifdef DAC_REFRESH_EN
  localparam int TW = $clog2(REFRESH_PERIOD + 1);

  logic [23:0]   shadow [8];
  logic [7:0]    shadow_valid;
  logic [2:0]    rr_ptr, rr_sel, rr_idx;
  logic          rr_found;
  logic [TW-1:0] idle_timer;
  logic          refresh_due;

  assign refresh_due  = (idle_timer == TW'(REFRESH_PERIOD - 1));
  assign refresh_go   = refresh_due && rr_found;
  assign refresh_word = shadow[rr_sel];

  // Round-robin search for the first valid shadow entry at or after rr_ptr
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = rr_ptr;
    rr_idx   = rr_ptr;
    for (int i = 7; i >= 0; i--) begin
      rr_idx = rr_ptr + 3'(i);
      if (shadow_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  // Shadow capture on FIFO issue, idle timer and refresh pointer advance
  always_ff @(posedge clk25) begin
    if (reset) begin
      shadow_valid   <= '0;
      rr_ptr         <= '0;
      idle_timer     <= '0;
      refresh_active <= 1'b0;
      for (int i = 0; i < 8; i++) shadow[i] <= '0;
    end else begin
      if (issue_fifo) begin
        shadow[head[18:16]]       <= head;
        shadow_valid[head[18:16]] <= 1'b1;
        idle_timer                <= '0;
        refresh_active            <= 1'b0;
      end else if (state == IDLE) begin
        if (refresh_due) begin
          idle_timer <= '0;
          if (rr_found) begin
            rr_ptr         <= rr_sel + 3'(1);
            refresh_active <= 1'b1;
          end
        end else begin
          idle_timer <= idle_timer + TW'(1);
        end
      end
    end
  end
`else
  assign refresh_go     = 1'b0;
  assign refresh_word   = '0;
  assign refresh_active = 1'b0;
`endif

endmodule

// File: tb/tb_dac_cmd_sequencer.sv
// tb/tb_dac_cmd_sequencer.sv - scoreboard bench for dac_cmd_sequencer (default build)
module tb_dac_cmd_sequencer;

  logic        clk25 = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_cmd, wr_addr;
  logic [15:0] wr_value;
  logic        wr_ready, overflow, busy, send_data, refresh_active;
  logic [3:0]  fifo_count;
  logic [3:0]  cmd, addr;
  logic [15:0] value;

  typedef struct {
    logic [23:0] word;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_strobe = 0;
  int   cyc_a;

  dac_cmd_sequencer dut (
    .clk25(clk25), .reset(reset), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
    .wr_value(wr_value), .wr_ready(wr_ready), .overflow(overflow), .fifo_count(fifo_count),
    .busy(busy), .cmd(cmd), .addr(addr), .value(value), .send_data(send_data),
    .refresh_active(refresh_active)
  );

  always #20 clk25 = ~clk25;

  always @(posedge clk25) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard, with the expected spacing
  always @(negedge clk25) begin
    if (reset === 1'b0 && send_data === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", {8'h0, cmd, addr, value}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_word", {8'h0, cmd, addr, value}, {8'h0, e.word});
        if (e.gap != 0) chk("strobe_gap", cyc - last_strobe, e.gap);
      end
      last_strobe = cyc;
    end
  end

  task automatic wr(input logic [3:0] c, input logic [3:0] a, input logic [15:0] v,
                    input bit expect_issue, input int gap);
    exp_t e;
    if (expect_issue) begin
      e.word = {c, a, v};
      e.gap  = gap;
      q.push_back(e);
    end
    wr_en = 1'b1; wr_cmd = c; wr_addr = a; wr_value = v;
    @(negedge clk25);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk25);
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_cmd = '0; wr_addr = '0; wr_value = '0;
    repeat (3) @(negedge clk25);
    reset = 1'b0;
    @(negedge clk25);

    // reset state
    chk("rst_count", fifo_count, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word", {cmd, addr, value}, 24'h0);
    chk("rst_send", send_data, 0);
    chk("rst_refresh", refresh_active, 0);

    // single write: strobe one cycle after the write edge, word held afterwards
    wr(4'h3, 4'h1, 16'hABCD, 1'b1, 0);
    chk("single_no_same_cycle", send_data, 0);
    chk("single_count", fifo_count, 1);
    chk("single_busy", busy, 1);
    @(negedge clk25);
    chk("single_send", send_data, 1);
    chk("single_count_after", fifo_count, 0);
    @(negedge clk25);
    chk("single_send_1cyc", send_data, 0);
    repeat (20) @(negedge clk25);
    chk("single_hold", {cmd, addr, value}, 24'h31ABCD);
    wait_idle(40);

    // burst of 8: FIFO order, 28-cycle spacing
    for (int i = 0; i < 8; i++)
      wr(4'(i + 1), 4'(7 - i), 16'h1000 + 16'(i * 17), 1'b1, (i == 0) ? 0 : 28);
    chk("burst_no_overflow", overflow, 0);
    wait_idle(300);
    chk("burst_count", fifo_count, 0);
    chk("burst_last_word", {cmd, addr, value}, {4'h8, 4'h0, 16'h1077});

    // fill to full during a frame, 9th write dropped
    wr(4'hA, 4'h2, 16'h5555, 1'b1, 0);
    @(negedge clk25);
    chk("ovf_first_send", send_data, 1);
    cyc_a = cyc;
    for (int i = 0; i < 8; i++)
      wr(4'h5, 4'(i), 16'hC000 + 16'(i), 1'b1, 28);
    wr(4'hF, 4'hF, 16'hDEAD, 1'b0, 0);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_wr_ready", wr_ready, 0);
    @(negedge clk25);
    chk("ovf_pulse_end", overflow, 0);

    // write while full on the same edge as a pop: dropped, count 8->7
    while (cyc < cyc_a + 27) @(negedge clk25);
    wr(4'hE, 4'hE, 16'hBEEF, 1'b0, 0);
    chk("popfull_overflow", overflow, 1);
    chk("popfull_count", fifo_count, 7);
    chk("popfull_send", send_data, 1);
    wait_idle(300);

    // reset ten cycles into a frame with a word still pending
    wr(4'h7, 4'h3, 16'h0123, 1'b1, 0);
    wr(4'h9, 4'h4, 16'h4567, 1'b0, 0);
    repeat (10) @(negedge clk25);
    reset = 1'b1;
    @(negedge clk25);
    reset = 1'b0;
    chk("midrst_send", send_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_word", {cmd, addr, value}, 24'h0);
    repeat (60) @(negedge clk25);
    chk("midrst_quiet_busy", busy, 0);
    wr(4'h2, 4'h6, 16'h8001, 1'b1, 0);
    @(negedge clk25);
    chk("post_rst_send", send_data, 1);
    wait_idle(40);

    chk("scoreboard_drained", q.size(), 0);
    chk("refresh_off", refresh_active, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
